// File: rtl/rossler_pkg.sv
// Shared types and constants for the Rossler forward-Euler sequencer.
package rossler_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 21;

  // Clamp limits kept wide; users take the top Width bits for their word size.
  localparam logic [63:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN = 64'h8000_0000_0000_0000;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  typedef enum logic [2:0] {IDLE, AY, ZC, HX, HY, HZ, UPD, OUT} state_e;

endpackage

// File: rtl/fxp_mul.sv
// Signed Width x Width fixed-point multiply, truncated to Width bits at Frac,
// with optional clamping when the scaled product does not fit.
module fxp_mul
  import rossler_pkg::*;
#(
  parameter int Width = WIDTH,
  parameter int Frac  = FRAC,
  parameter bit SatEn = 1'b0
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] p_o,
  output logic             sat_o
);

  localparam logic [Width-1:0] SatMax = SAT_MAX[63 -: Width];
  localparam logic [Width-1:0] SatMin = SAT_MIN[63 -: Width];

  logic signed [2*Width-1:0] prod;
  logic [Width-Frac:0]       hi;
  logic                      fits;
  logic                      unused_lsb;

  assign prod       = $signed(a_i) * $signed(b_i);
  assign hi         = prod[2*Width-1:Frac+Width-1];
  assign fits       = (&hi) | ~(|hi);
  assign unused_lsb = ^prod[Frac-1:0];

  always_comb begin
    p_o   = prod[Frac+Width-1:Frac];
    sat_o = 1'b0;
    if (SatEn && !fits) begin
      sat_o = 1'b1;
      p_o   = prod[2*Width-1] ? SatMin : SatMax;
    end
  end

endmodule

// File: rtl/rossler_euler_ctrl.sv
// Forward-Euler Rossler sequencer sharing one fixed-point multiplier across
// the five products of a step. Define ROSSLER_SAT_EN for saturating math.
module rossler_euler_ctrl
  import rossler_pkg::*;
#(
  parameter int Width     = WIDTH,
  parameter int Frac      = FRAC,
  parameter int IterWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [IterWidth-1:0] n_iter_i,
  input  logic [Width-1:0]     a_i,
  input  logic [Width-1:0]     b_i,
  input  logic [Width-1:0]     c_i,
  input  logic [Width-1:0]     h_i,
  input  logic [Width-1:0]     x0_i,
  input  logic [Width-1:0]     y0_i,
  input  logic [Width-1:0]     z0_i,
  output logic [Width-1:0]     x_o,
  output logic [Width-1:0]     y_o,
  output logic [Width-1:0]     z_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IterWidth-1:0] iter_o,
  output logic                 ovf_o
);

`ifdef ROSSLER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif
  localparam logic [Width-1:0] SatMax = SAT_MAX[63 -: Width];
  localparam logic [Width-1:0] SatMin = SAT_MIN[63 -: Width];

  state_e state_q, state_d;
  logic [Width-1:0] a_q, b_q, c_q, h_q, x_q, y_q, z_q;
  logic [Width-1:0] t1_q, t2_q, kx_q, ky_q, kz_q;
  logic [IterWidth-1:0] iter_q;
  logic stop_q, valid_q, busy_q, done_q, done_d;
  logic [Width-1:0] mul_a, mul_b, mul_p;
  logic mul_sat, step_ovf;

  function automatic logic signed [Width+1:0] ext(input logic [Width-1:0] v);
    return {{2{v[Width-1]}}, v};
  endfunction

  // Sums are formed two bits wide so both the wrapped and the clamped result
  // come from one exact value; returns {clamped, result}.
  function automatic logic [Width:0] fit(input logic signed [Width+1:0] v);
    logic top_same;
    top_same = (&v[Width+1:Width-1]) | ~(|v[Width+1:Width-1]);
    if (SatEn && !top_same) return {1'b1, v[Width+1] ? SatMin : SatMax};
    return {1'b0, v[Width-1:0]};
  endfunction

  logic [Width:0] s_xc, s_nyz, s_xt1, s_bt2, u_x, u_y, u_z;
  assign s_xc  = fit(ext(x_q) - ext(c_q));
  assign s_nyz = fit(-ext(y_q) - ext(z_q));
  assign s_xt1 = fit(ext(x_q) + ext(t1_q));
  assign s_bt2 = fit(ext(b_q) + ext(t2_q));
  assign u_x   = fit(ext(x_q) + ext(kx_q));
  assign u_y   = fit(ext(y_q) + ext(ky_q));
  assign u_z   = fit(ext(z_q) + ext(kz_q));

  fxp_mul #(.Width(Width), .Frac(Frac), .SatEn(SatEn)) u_mul (
    .a_i(mul_a), .b_i(mul_b), .p_o(mul_p), .sat_o(mul_sat)
  );

  always_comb begin
    mul_a    = h_q;
    mul_b    = '0;
    step_ovf = 1'b0;
    case (state_q)
      AY:  begin mul_a = a_q; mul_b = y_q; step_ovf = mul_sat; end
      ZC:  begin mul_a = z_q; mul_b = s_xc[Width-1:0];  step_ovf = mul_sat | s_xc[Width];  end
      HX:  begin mul_b = s_nyz[Width-1:0]; step_ovf = mul_sat | s_nyz[Width]; end
      HY:  begin mul_b = s_xt1[Width-1:0]; step_ovf = mul_sat | s_xt1[Width]; end
      HZ:  begin mul_b = s_bt2[Width-1:0]; step_ovf = mul_sat | s_bt2[Width]; end
      UPD: step_ovf = u_x[Width] | u_y[Width] | u_z[Width];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = AY;
      AY:   state_d = ZC;
      ZC:   state_d = HX;
      HX:   state_d = HY;
      HY:   state_d = HZ;
      HZ:   state_d = UPD;
      UPD:  state_d = OUT;
      OUT: if (ready_i) begin
        if (stop_q || (n_iter_i != '0 && iter_q == n_iter_i)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = AY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      iter_q  <= '0;
      {a_q, b_q, c_q, h_q}         <= '0;
      {x_q, y_q, z_q}              <= '0;
      {t1_q, t2_q, kx_q, ky_q, kz_q} <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == OUT);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      if (state_q != IDLE && stop_i) stop_q <= 1'b1;
      case (state_q)
        IDLE: if (start_i) begin
          {a_q, b_q, c_q, h_q} <= {a_i, b_i, c_i, h_i};
          {x_q, y_q, z_q}      <= {x0_i, y0_i, z0_i};
          iter_q <= '0;
          stop_q <= 1'b0;
        end
        AY:  t1_q <= mul_p;
        ZC:  t2_q <= mul_p;
        HX:  kx_q <= mul_p;
        HY:  ky_q <= mul_p;
        HZ:  kz_q <= mul_p;
        UPD: begin
          x_q    <= u_x[Width-1:0];
          y_q    <= u_y[Width-1:0];
          z_q    <= u_z[Width-1:0];
          iter_q <= iter_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ROSSLER_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                          ovf_q <= 1'b0;
    else if (state_q == IDLE && start_i) ovf_q <= 1'b0;
    else if (step_ovf)                  ovf_q <= 1'b1;
  end
  assign ovf_o = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = step_ovf;
  assign ovf_o      = 1'b0;
`endif

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign iter_o  = iter_q;

endmodule

// File: tb/tb_rossler_euler_ctrl.sv
// Self-checking bench for rossler_euler_ctrl: constant vectors, timing
// sequences and a longint reference model of the Euler step.
module tb_rossler_euler_ctrl;
  import rossler_pkg::*;

`ifdef ROSSLER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, ready = 1'b1;
  logic [15:0] n_iter = '0;
  logic [31:0] a = '0, b = '0, c = '0, h = '0, x0 = '0, y0 = '0, z0 = '0;
  logic [31:0] x, y, z;
  logic valid, busy, done, ovf;
  logic [15:0] iter;

  rossler_euler_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .n_iter_i(n_iter),
    .a_i(a), .b_i(b), .c_i(c), .h_i(h), .x0_i(x0), .y0_i(y0), .z0_i(z0),
    .x_o(x), .y_o(y), .z_o(z), .valid_o(valid), .ready_i(ready),
    .busy_o(busy), .done_o(done), .iter_o(iter), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: exact 64-bit arithmetic, then clamp or wrap to 32 bits.
  longint ma, mb, mc, mh, mx, my, mz;
  bit movf;

  function automatic longint fa(input longint s);
    int t;
    if (SAT) begin
      if (s > MAXV) begin movf = 1'b1; return MAXV; end
      if (s < MINV) begin movf = 1'b1; return MINV; end
      return s;
    end
    t = int'(s);
    return longint'(t);
  endfunction

  function automatic longint fm(input longint p, input longint q);
    return fa((p * q) >>> FRAC);
  endfunction

  function automatic longint s32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_step;
    longint t1, t2, kx, ky, kz;
    t1 = fm(ma, my);
    t2 = fm(mz, fa(mx - mc));
    kx = fm(mh, fa(-my - mz));
    ky = fm(mh, fa(mx + t1));
    kz = fm(mh, fa(mb + t2));
    mx = fa(mx + kx);
    my = fa(my + ky);
    mz = fa(mz + kz);
  endtask

  task automatic set_params(input logic [31:0] pa, pb, pc, ph, px, py, pz);
    a = pa; b = pb; c = pc; h = ph; x0 = px; y0 = py; z0 = pz;
    ma = s32(pa); mb = s32(pb); mc = s32(pc); mh = s32(ph);
    mx = s32(px); my = s32(py); mz = s32(pz);
    movf = 1'b0;
  endtask

  // Returns one cycle after the start edge (cycle T+1).
  task automatic start_run;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_basic(input string tag);
    set_params(0, 0, 0, ONE >> 1, ONE, 0, 0);
    n_iter = 16'd2;
    ready  = 1'b1;
    start_run();
    chk({tag, "_busy_rise"}, busy, 1);
    repeat (5) tick();
    chk({tag, "_valid_T6"}, valid, 0);
    tick();
    chk({tag, "_valid_T7"}, valid, 1);
    chk({tag, "_x1"}, x, 32'h0020_0000);
    chk({tag, "_y1"}, y, 32'h0010_0000);
    chk({tag, "_z1"}, z, 32'h0);
    chk({tag, "_iter1"}, iter, 1);
    tick();
    chk({tag, "_valid_T8"}, valid, 0);
    repeat (5) tick();
    chk({tag, "_valid_T13"}, valid, 0);
    tick();
    chk({tag, "_valid_T14"}, valid, 1);
    chk({tag, "_x2"}, x, 32'h0018_0000);
    chk({tag, "_y2"}, y, 32'h0020_0000);
    chk({tag, "_z2"}, z, 32'h0);
    chk({tag, "_iter2"}, iter, 2);
    chk({tag, "_done_T14"}, done, 0);
    tick();
    chk({tag, "_done_T15"}, done, 1);
    chk({tag, "_busy_T15"}, busy, 0);
    tick();
    chk({tag, "_done_T16"}, done, 0);
  endtask

  // Runs n steps, comparing every valid cycle against the model.
  task automatic run_model(input string tag, input int n, input bit rnd);
    int k, to;
    bit have, rdy;
    k = 0; to = 0; have = 1'b0;
    n_iter = 16'(n);
    start_run();
    while (k < n && to < 40 * n + 50) begin
      if (valid && !have) begin
        model_step();
        have = 1'b1;
      end
      if (valid) begin
        chk({tag, "_x"}, x, 32'(mx));
        chk({tag, "_y"}, y, 32'(my));
        chk({tag, "_z"}, z, 32'(mz));
        chk({tag, "_iter"}, iter, 32'((k + 1) % 65536));
        chk({tag, "_ovf"}, ovf, movf);
      end
      rdy = rnd ? 1'($urandom_range(1)) : 1'b1;
      ready = rdy;
      tick();
      to++;
      if (have && rdy) begin
        k++;
        have = 1'b0;
      end
    end
    chk({tag, "_completed"}, k, n);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_end"}, busy, 0);
    ready = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [31:0] a, b, c, h, x0, y0, z0;
    logic [31:0] ex, ey, ez;
  } vec_t;
  vec_t tv[5];

  initial begin
    logic [31:0] hold_x, exp_y;
    int cnt;
    bit ok;

    tv[0] = '{32'h0, 32'h0, 32'h0, 32'h0010_0000, 32'h0020_0000, 32'h0, 32'h0,
              32'h0020_0000, 32'h0010_0000, 32'h0};
    tv[1] = '{32'h0, 32'h0, 32'h0, 32'h0020_0000, 32'h0, 32'h0020_0000, 32'h0,
              32'hFFE0_0000, 32'h0020_0000, 32'h0};
    tv[2] = '{32'h0, 32'h0020_0000, 32'h0, 32'h0010_0000, 32'h0, 32'h0, 32'h0,
              32'h0, 32'h0, 32'h0010_0000};
    tv[3] = '{32'h0020_0000, 32'h0, 32'h0, 32'h0008_0000, 32'h0, 32'h0020_0000, 32'h0,
              32'hFFF8_0000, 32'h0028_0000, 32'h0};
    tv[4] = '{32'h0, 32'h0, 32'h0040_0000, 32'h0010_0000, 32'h0, 32'h0, 32'h0020_0000,
              32'hFFF0_0000, 32'h0, 32'h0};

    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x", x, 0);
    chk("rst_iter", iter, 0);
    chk("rst_ovf", ovf, 0);

    // One-step vectors
    for (int i = 0; i < 5; i++) begin
      set_params(tv[i].a, tv[i].b, tv[i].c, tv[i].h, tv[i].x0, tv[i].y0, tv[i].z0);
      n_iter = 16'd1;
      ready  = 1'b1;
      start_run();
      repeat (6) tick();
      chk($sformatf("vec%0d_valid", i), valid, 1);
      chk($sformatf("vec%0d_x", i), x, tv[i].ex);
      chk($sformatf("vec%0d_y", i), y, tv[i].ey);
      chk($sformatf("vec%0d_z", i), z, tv[i].ez);
      tick();
      chk($sformatf("vec%0d_done", i), done, 1);
      tick();
    end

    run_basic("basic");

    // Backpressure: sample 1 held for 5 cycles
    set_params(0, 0, 0, ONE >> 1, ONE, 0, 0);
    n_iter = 16'd2;
    ready  = 1'b0;
    start_run();
    repeat (6) tick();
    hold_x = x;
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (!(valid && x == 32'h0020_0000 && y == 32'h0010_0000 && iter == 16'd1)) ok = 1'b0;
    end
    chk("bp_hold", ok, 1);
    chk("bp_x_held", hold_x, 32'h0020_0000);
    ready = 1'b1;
    tick();
    chk("bp_release_valid", valid, 0);
    cnt = 0;
    while (!valid && cnt < 10) begin tick(); cnt++; end
    chk("bp_wait_cycles", cnt, 6);
    chk("bp_x2", x, 32'h0018_0000);
    chk("bp_y2", y, 32'h0020_0000);
    tick();
    chk("bp_done", done, 1);
    tick();

    // Stop at T+3 in free-run, with a start pulse while busy
    set_params(0, 0, 0, ONE >> 1, ONE, 0, 0);
    n_iter = 16'd0;
    start_run();
    repeat (2) tick();
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    repeat (3) tick();
    chk("stop_valid_T7", valid, 1);
    chk("stop_x1", x, 32'h0020_0000);
    chk("stop_iter", iter, 1);
    tick();
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    cnt = 0;
    repeat (10) begin tick(); cnt += int'(valid) + int'(busy); end
    chk("stop_quiet", cnt, 0);

    // Overflow corner
    set_params(ONE, 0, 0, ONE, 32'h7D00_0000, 32'h7D00_0000, 0);
    exp_y = SAT ? 32'h7FFF_FFFF : 32'h7700_0000;
    run_model("ovf", 1, 1'b0);
    chk("ovf_y", y, exp_y);
    chk("ovf_flag", ovf, SAT);

    // Reset in HY, then a fresh run must match the basic results
    set_params(0, 0, 0, ONE >> 1, ONE, 0, 0);
    n_iter = 16'd2;
    start_run();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_xyz", x | y | z, 0);
    chk("mrst_iter", iter, 0);
    cnt = 0;
    repeat (8) begin tick(); cnt += int'(valid) + int'(busy); end
    chk("mrst_idle", cnt, 0);
    run_basic("rerun");

    // Randomized runs with random backpressure
    for (int r = 0; r < 8; r++) begin
      set_params($urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom());
      run_model($sformatf("rand%0d", r), int'($urandom_range(4, 1)), 1'b1);
    end

    // Long run with classic parameters
    set_params(32'h0006_6666, 32'h0006_6666, 32'h00B6_6666, 32'h0000_0831,
               32'h0003_3333, 32'h0003_3333, 32'h0003_3333);
    run_model("long", 1000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
